// File: rtl/led7seg_pkg.sv
// Shared 7-segment glyph table and code constants used by both the display encoder
// and the scan decoder, plus the decoder's FSM state type.
package led7seg_pkg;

  // Patterns are seg[0:6] = a..g, active-low (0 = segment lit).
  localparam logic [0:6] SEG_0     = 7'b0000001;
  localparam logic [0:6] SEG_1     = 7'b1001111;
  localparam logic [0:6] SEG_2     = 7'b0010010;
  localparam logic [0:6] SEG_3     = 7'b0000110;
  localparam logic [0:6] SEG_4     = 7'b1001100;
  localparam logic [0:6] SEG_5     = 7'b0100100;
  localparam logic [0:6] SEG_6     = 7'b0100000;
  localparam logic [0:6] SEG_7     = 7'b0001111;
  localparam logic [0:6] SEG_8     = 7'b0000000;
  localparam logic [0:6] SEG_9     = 7'b0000100;
  localparam logic [0:6] SEG_DASH  = 7'b1111110;
  localparam logic [0:6] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] CODE_DASH    = 4'hA;
  localparam logic [3:0] CODE_INVALID = 4'hE;
  localparam logic [3:0] CODE_BLANK   = 4'hF;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_COMMIT = 2'd1,
    ST_HOLD   = 2'd2
  } scan_state_e;

endpackage

// File: rtl/led7seg_pattern_decode.sv
// Combinational inverse of the glyph table: active-low segment pattern to 4-bit code.
// Patterns outside the table decode to CODE_INVALID with invalid raised.
module led7seg_pattern_decode
  import led7seg_pkg::*;
(
  input  logic [0:6] seg,
  output logic [3:0] code,
  output logic       invalid
);

  // table lookup; unknown patterns fall through to the invalid code
  always_comb begin
    code    = CODE_INVALID;
    invalid = 1'b0;
    case (seg)
      SEG_0:     code = 4'h0;
      SEG_1:     code = 4'h1;
      SEG_2:     code = 4'h2;
      SEG_3:     code = 4'h3;
      SEG_4:     code = 4'h4;
      SEG_5:     code = 4'h5;
      SEG_6:     code = 4'h6;
      SEG_7:     code = 4'h7;
      SEG_8:     code = 4'h8;
      SEG_9:     code = 4'h9;
      SEG_DASH:  code = CODE_DASH;
      SEG_BLANK: code = CODE_BLANK;
      default: begin
        code    = CODE_INVALID;
        invalid = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/led7seg_scan_decoder.sv
// Readback monitor for a multiplexed active-low 7-segment bus: synchronises the pins,
// waits for a stable {select,segment} sample, and commits the decoded digit per select.
module led7seg_scan_decoder
  import led7seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 8,
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [0:6]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel_n,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    frame_done,
  output logic                    sel_err
);

  localparam logic [CNT_W-1:0]      CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]      CNT_ONE = CNT_W'(1);
  localparam logic [NUM_DIGITS-1:0] DIG_ONE = NUM_DIGITS'(1);

  logic [0:6]              seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d, smp_seg_q, smp_seg_d;
  logic [NUM_DIGITS-1:0]   sel_s1_q, sel_s1_d, sel_s2_q, sel_s2_d, smp_sel_q, smp_sel_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  scan_state_e             state_q, state_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   digit_err_q, digit_err_d, seen_q, seen_d;
  logic                    frame_done_q, frame_done_d, sel_err_q, sel_err_d;

  logic                    same_s, commit_s, any_low_s, multi_low_s, dec_invalid_s;
  logic [NUM_DIGITS-1:0]   low_s;
  logic [3:0]              dec_code_s;

  led7seg_pattern_decode u_decode (
    .seg     (smp_seg_q),
    .code    (dec_code_s),
    .invalid (dec_invalid_s)
  );

  // next-state: synchronisers, stability counter, FSM and commit into the register file
  always_comb begin
    seg_s1_d  = seg_in;
    seg_s2_d  = seg_s1_q;
    sel_s1_d  = dig_sel_n;
    sel_s2_d  = sel_s1_q;
    smp_seg_d = seg_s2_q;
    smp_sel_d = sel_s2_q;

    same_s = (seg_s2_q == smp_seg_q) && (sel_s2_q == smp_sel_q);
    if (!same_s) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end

    state_d  = state_q;
    commit_s = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (same_s && (cnt_d == CNT_MAX)) state_d = ST_COMMIT;
        else                              state_d = ST_WAIT;
      end
      ST_COMMIT: begin
        commit_s = 1'b1;
        // a change landing in the commit cycle must not be swallowed by HOLD
        if (same_s) state_d = ST_HOLD;
        else        state_d = ST_WAIT;
      end
      ST_HOLD: begin
        if (same_s) state_d = ST_HOLD;
        else        state_d = ST_WAIT;
      end
      default: state_d = ST_WAIT;
    endcase

    low_s       = ~smp_sel_q;
    any_low_s   = |low_s;
    multi_low_s = |(low_s & (low_s - DIG_ONE));

    digits_d     = digits_q;
    digit_err_d  = digit_err_q;
    seen_d       = seen_q;
    frame_done_d = 1'b0;
    sel_err_d    = sel_err_q;
    if (commit_s && multi_low_s) begin
      sel_err_d = 1'b1;
    end else if (commit_s && any_low_s) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (low_s[k]) begin
          digits_d[4*k +: 4] = dec_code_s;
          digit_err_d[k]     = dec_invalid_s;
          seen_d[k]          = 1'b1;
        end else begin
          digits_d[4*k +: 4] = digits_q[4*k +: 4];
        end
      end
      if (&seen_d) begin
        frame_done_d = 1'b1;
        seen_d       = '0;
      end else begin
        frame_done_d = 1'b0;
      end
    end else begin
      sel_err_d = sel_err_q;
    end
  end

  // state register; reset wins over any pending commit
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_s1_q     <= 7'h7F;
      seg_s2_q     <= 7'h7F;
      smp_seg_q    <= 7'h7F;
      sel_s1_q     <= '1;
      sel_s2_q     <= '1;
      smp_sel_q    <= '1;
      cnt_q        <= '0;
      state_q      <= ST_WAIT;
      digits_q     <= '1;
      digit_err_q  <= '0;
      seen_q       <= '0;
      frame_done_q <= 1'b0;
      sel_err_q    <= 1'b0;
    end else begin
      seg_s1_q     <= seg_s1_d;
      seg_s2_q     <= seg_s2_d;
      smp_seg_q    <= smp_seg_d;
      sel_s1_q     <= sel_s1_d;
      sel_s2_q     <= sel_s2_d;
      smp_sel_q    <= smp_sel_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      digits_q     <= digits_d;
      digit_err_q  <= digit_err_d;
      seen_q       <= seen_d;
      frame_done_q <= frame_done_d;
      sel_err_q    <= sel_err_d;
    end
  end

  assign digits     = digits_q;
  assign digit_err  = digit_err_q;
  assign frame_done = frame_done_q;
  assign sel_err    = sel_err_q;

endmodule

// File: tb/tb_led7seg_scan_decoder.sv
// Directed self-checking bench for led7seg_scan_decoder (NUM_DIGITS=8, STABLE_CYCLES=16).
module tb_led7seg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [0:6]  seg_in = 7'b1111111;
  logic [7:0]  dig_sel_n = 8'hFF;
  logic [31:0] digits;
  logic [7:0]  digit_err;
  logic        frame_done;
  logic        sel_err;

  int tests_run    = 0;
  int tests_failed = 0;
  int fd_cnt       = 0;

  led7seg_scan_decoder #(.NUM_DIGITS(8), .STABLE_CYCLES(16), .CNT_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .seg_in     (seg_in),
    .dig_sel_n  (dig_sel_n),
    .digits     (digits),
    .digit_err  (digit_err),
    .frame_done (frame_done),
    .sel_err    (sel_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_cnt++;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_pins(input int k, input logic [0:6] pat);
    logic [7:0] sel;
    sel = 8'hFF;
    if (k >= 0) sel[k] = 1'b0;
    seg_in    = pat;
    dig_sel_n = sel;
  endtask

  task automatic show(input int k, input logic [0:6] pat, input int n);
    set_pins(k, pat);
    wait_cycles(n);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      seg_in    = 7'($urandom);
      dig_sel_n = 8'($urandom);
      wait_cycles(1);
    end
    tests_run += 4;
    if (digits !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL reset_digits got %h want ffffffff", digits); end
    if (digit_err !== 8'h00) begin tests_failed++; $display("FAIL reset_digit_err got %h want 00", digit_err); end
    if (frame_done !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
    if (sel_err !== 1'b0) begin tests_failed++; $display("FAIL reset_sel_err got %b want 0", sel_err); end
    set_pins(-1, 7'b1111111);
    rst = 1'b0;
    wait_cycles(25);
  endtask

  task automatic test_scan;
    logic [0:6] pat [8];
    int fd0;
    pat = '{7'b1001111, 7'b0010010, 7'b1111110, 7'b1001100,
            7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000};
    fd0 = fd_cnt;
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 8; k++) begin
        show(k, pat[k], 20);
        show(-1, 7'b1111111, 2);
      end
      tests_run += 3;
      if (digits !== 32'h87654A21) begin tests_failed++; $display("FAIL scan_digits pass %0d got %h want 87654a21", p, digits); end
      if (digit_err !== 8'h00) begin tests_failed++; $display("FAIL scan_digit_err pass %0d got %h want 00", p, digit_err); end
      if (fd_cnt - fd0 !== p + 1) begin tests_failed++; $display("FAIL scan_frame_done pass %0d got %0d pulses want %0d", p, fd_cnt - fd0, p + 1); end
    end
  endtask

  task automatic test_short_glitch;
    show(3, 7'b0100100, 15);
    show(-1, 7'b1111111, 25);
    tests_run += 2;
    if (digits[15:12] !== 4'h4) begin tests_failed++; $display("FAIL glitch_digit3 got %h want 4", digits[15:12]); end
    if (digits !== 32'h87654A21) begin tests_failed++; $display("FAIL glitch_digits got %h want 87654a21", digits); end
  endtask

  task automatic test_invalid_glyph;
    show(2, 7'b1010101, 18);
    tests_run += 3;
    if (digits[11:8] !== 4'hA) begin tests_failed++; $display("FAIL latency_early_d2 got %h want a", digits[11:8]); end
    wait_cycles(1);
    if (digits[11:8] !== 4'hE) begin tests_failed++; $display("FAIL invalid_code got %h want e", digits[11:8]); end
    if (digit_err !== 8'h04) begin tests_failed++; $display("FAIL invalid_err got %h want 04", digit_err); end
    show(2, 7'b0000110, 18);
    tests_run += 3;
    if (digits[11:8] !== 4'hE) begin tests_failed++; $display("FAIL latency_early_d3 got %h want e", digits[11:8]); end
    wait_cycles(1);
    if (digits !== 32'h87654321) begin tests_failed++; $display("FAIL valid_digits got %h want 87654321", digits); end
    if (digit_err !== 8'h00) begin tests_failed++; $display("FAIL valid_err got %h want 00", digit_err); end
    show(-1, 7'b1111111, 5);
  endtask

  task automatic test_sel_err;
    seg_in    = 7'b0000000;
    dig_sel_n = 8'b1111_1100;
    wait_cycles(25);
    tests_run += 2;
    if (sel_err !== 1'b1) begin tests_failed++; $display("FAIL sel_err_set got %b want 1", sel_err); end
    if (digits !== 32'h87654321) begin tests_failed++; $display("FAIL sel_err_nowrite got %h want 87654321", digits); end
    show(0, 7'b0000001, 25);
    show(-1, 7'b1111111, 5);
    tests_run += 2;
    if (sel_err !== 1'b1) begin tests_failed++; $display("FAIL sel_err_sticky got %b want 1", sel_err); end
    if (digits !== 32'h87654320) begin tests_failed++; $display("FAIL sel_err_after got %h want 87654320", digits); end
  endtask

  task automatic test_reset_mid_commit;
    logic [0:6] pat [8];
    int fd0;
    pat = '{7'b0000100, 7'b0000001, 7'b1111111, 7'b0001111,
            7'b0000110, 7'b0010010, 7'b0100000, 7'b0100100};
    rst = 1'b1;
    wait_cycles(1);
    rst = 1'b0;
    tests_run += 2;
    if (sel_err !== 1'b0) begin tests_failed++; $display("FAIL rst_sel_err got %b want 0", sel_err); end
    if (digits !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL rst_digits got %h want ffffffff", digits); end
    wait_cycles(20);
    fd0 = fd_cnt;
    for (int k = 0; k < 8; k++) begin
      if (k != 5) show(k, pat[k], 20);
    end
    show(5, 7'b0000000, 18);
    rst = 1'b1;
    set_pins(-1, 7'b1111111);
    wait_cycles(1);
    rst = 1'b0;
    tests_run += 3;
    if (digits !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL midcommit_digits got %h want ffffffff", digits); end
    if (digit_err !== 8'h00) begin tests_failed++; $display("FAIL midcommit_err got %h want 00", digit_err); end
    if (fd_cnt - fd0 !== 0) begin tests_failed++; $display("FAIL midcommit_frame_done got %0d pulses want 0", fd_cnt - fd0); end
    wait_cycles(25);
    show(5, pat[5], 20);
    tests_run += 2;
    if (digits !== 32'hFF2F_FFFF) begin tests_failed++; $display("FAIL seen_cleared_digits got %h want ff2fffff", digits); end
    if (fd_cnt - fd0 !== 0) begin tests_failed++; $display("FAIL seen_cleared_frame got %0d pulses want 0", fd_cnt - fd0); end
    for (int k = 0; k < 8; k++) begin
      if (k != 5) show(k, pat[k], 20);
    end
    show(-1, 7'b1111111, 5);
    tests_run += 3;
    if (digits !== 32'h5623_7F09) begin tests_failed++; $display("FAIL refill_digits got %h want 56237f09", digits); end
    if (digit_err !== 8'h00) begin tests_failed++; $display("FAIL refill_err got %h want 00", digit_err); end
    if (fd_cnt - fd0 !== 1) begin tests_failed++; $display("FAIL refill_frame got %0d pulses want 1", fd_cnt - fd0); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_short_glitch();
    test_invalid_glyph();
    test_sel_err();
    test_reset_mid_commit();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
